// File: rtl/ir_decode_stage.sv
// Fetch-to-register-bank pipeline register: captures one instruction per handshake,
// decodes both AR and T field candidates plus their mux selects, and owns HALT state.
module ir_decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_instr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       rd_ar,
  output logic [3:0]       rd_t,
  output logic [31:0]      const_ar,
  output logic [31:0]      const_t,
  output logic             dst_sel,
  output logic             const_sel,
  output logic [3:0]       rs1,
  output logic [3:0]       rs2,
  output logic             is_branch,
  output logic             halted,
  output logic [CNT_W-1:0] dec_count
);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  localparam logic [1:0] CLS_AR     = 2'b00;
  localparam logic [1:0] CLS_T      = 2'b01;
  localparam logic [1:0] CLS_BRANCH = 2'b10;
  localparam logic [1:0] CLS_HALT   = 2'b11;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [3:0]         rd_ar_q, rd_ar_d;
  logic [3:0]         rd_t_q, rd_t_d;
  logic [31:0]        const_ar_q, const_ar_d;
  logic [31:0]        const_t_q, const_t_d;
  logic               dst_sel_q, dst_sel_d;
  logic               const_sel_q, const_sel_d;
  logic [3:0]         rs1_q, rs1_d;
  logic [3:0]         rs2_q, rs2_d;
  logic               is_branch_q, is_branch_d;
  logic [CNT_W-1:0]   dec_count_q, dec_count_d;

  logic               ready_c;
  logic               accept_c;
  logic               load_c;
  logic [1:0]         cls_c;

  // instr[29:28] carry no meaning for this stage
  logic               unused_instr_bits;
  assign unused_instr_bits = ^in_instr[29:28];

  assign cls_c    = in_instr[31:30];
  assign ready_c  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept_c = in_valid && ready_c;
  // flush drops a coincident accept entirely: no load, no count, no HALT entry
  assign load_c   = accept_c && !flush;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    rd_ar_d     = rd_ar_q;
    rd_t_d      = rd_t_q;
    const_ar_d  = const_ar_q;
    const_t_d   = const_t_q;
    dst_sel_d   = dst_sel_q;
    const_sel_d = const_sel_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    is_branch_d = is_branch_q;
    dec_count_d = dec_count_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load_c) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (load_c) begin
      rd_ar_d     = in_instr[23:20];
      rd_t_d      = in_instr[27:24];
      rs1_d       = in_instr[19:16];
      rs2_d       = in_instr[15:12];
      const_ar_d  = {20'b0, in_instr[11:0]};
      const_t_d   = {{16{in_instr[15]}}, in_instr[15:0]};
      dst_sel_d   = (cls_c == CLS_T);
      const_sel_d = (cls_c == CLS_T);
      is_branch_d = (cls_c == CLS_BRANCH);
      dec_count_d = dec_count_q + CNT_W'(1);
    end

    case (state_q)
      RUN: begin
        if (load_c && (cls_c == CLS_HALT)) begin
          state_d = HALT;
        end
      end
      HALT: begin
        // only reset leaves HALT
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // CLS_AR needs no special handling beyond the zero defaults of the selects
    if (cls_c == CLS_AR) begin
      dst_sel_d = dst_sel_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      rd_ar_q     <= '0;
      rd_t_q      <= '0;
      const_ar_q  <= '0;
      const_t_q   <= '0;
      dst_sel_q   <= 1'b0;
      const_sel_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      is_branch_q <= 1'b0;
      dec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      rd_ar_q     <= rd_ar_d;
      rd_t_q      <= rd_t_d;
      const_ar_q  <= const_ar_d;
      const_t_q   <= const_t_d;
      dst_sel_q   <= dst_sel_d;
      const_sel_q <= const_sel_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      is_branch_q <= is_branch_d;
      dec_count_q <= dec_count_d;
    end
  end

  assign in_ready  = ready_c;
  assign out_valid = out_valid_q;
  assign rd_ar     = rd_ar_q;
  assign rd_t      = rd_t_q;
  assign const_ar  = const_ar_q;
  assign const_t   = const_t_q;
  assign dst_sel   = dst_sel_q;
  assign const_sel = const_sel_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign is_branch = is_branch_q;
  assign halted    = (state_q == HALT);
  assign dec_count = dec_count_q;

endmodule

// File: tb/tb_ir_decode_stage.sv
// Directed bench for ir_decode_stage: a scoreboard queue holds the decode expected
// for each accepted word and is compared while the word is held on the output.
module tb_ir_decode_stage;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [31:0]      in_instr;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [3:0]       rd_ar;
  logic [3:0]       rd_t;
  logic [31:0]      const_ar;
  logic [31:0]      const_t;
  logic             dst_sel;
  logic             const_sel;
  logic [3:0]       rs1;
  logic [3:0]       rs2;
  logic             is_branch;
  logic             halted;
  logic [CNT_W-1:0] dec_count;

  ir_decode_stage #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_instr  (in_instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .rd_ar     (rd_ar),
    .rd_t      (rd_t),
    .const_ar  (const_ar),
    .const_t   (const_t),
    .dst_sel   (dst_sel),
    .const_sel (const_sel),
    .rs1       (rs1),
    .rs2       (rs2),
    .is_branch (is_branch),
    .halted    (halted),
    .dec_count (dec_count)
  );

  typedef struct packed {
    logic [3:0]  rd_ar;
    logic [3:0]  rd_t;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] const_ar;
    logic [31:0] const_t;
    logic        dst_sel;
    logic        const_sel;
    logic        is_branch;
  } exp_t;

  exp_t             exp_q[$];
  logic             m_valid;
  logic             m_halted;
  logic [CNT_W-1:0] m_count;
  int               checks;
  int               errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model_decode(input logic [31:0] w);
    exp_t e;
    e.rd_ar     = w[23:20];
    e.rd_t      = w[27:24];
    e.rs1       = w[19:16];
    e.rs2       = w[15:12];
    e.const_ar  = w & 32'h0000_0FFF;
    e.const_t   = 32'($signed(w[15:0]));
    e.dst_sel   = (w[31:30] == 2'b01);
    e.const_sel = (w[31:30] == 2'b01);
    e.is_branch = (w[31:30] == 2'b10);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_halted = 1'b0;
    m_count  = '0;
    exp_q.delete();
  endtask

  // one clock of stimulus: check held output at negedge, update model at posedge
  task automatic step(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    logic m_ready;
    logic acc;
    exp_t e;
    in_valid  = v;
    in_instr  = w;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    m_ready = !m_halted && (!m_valid || rdy);
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready});
    chk("out_valid_held", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
        e = exp_q[0];
        chk("rd_ar",     {28'b0, rd_ar}, {28'b0, e.rd_ar});
        chk("rd_t",      {28'b0, rd_t},  {28'b0, e.rd_t});
        chk("rs1",       {28'b0, rs1},   {28'b0, e.rs1});
        chk("rs2",       {28'b0, rs2},   {28'b0, e.rs2});
        chk("const_ar",  const_ar, e.const_ar);
        chk("const_t",   const_t,  e.const_t);
        chk("dst_sel",   {31'b0, dst_sel},   {31'b0, e.dst_sel});
        chk("const_sel", {31'b0, const_sel}, {31'b0, e.const_sel});
        chk("is_branch", {31'b0, is_branch}, {31'b0, e.is_branch});
        if (rdy) void'(exp_q.pop_front());
      end
    end
    acc = v && m_ready;
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
      exp_q.delete();
    end else if (acc) begin
      exp_q.push_back(model_decode(w));
      m_valid = 1'b1;
      m_count = m_count + 1'b1;
      if (w[31:30] == 2'b11) m_halted = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("halted",    {31'b0, halted},    {31'b0, m_halted});
    chk("dec_count", 32'(dec_count),     32'(m_count));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h1234_5ABC;
    out_ready = 1'b0;
    flush     = 1'b0;
    model_reset();

    // reset with clock running and in_valid high
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_halted",    {31'b0, halted},    32'd0);
    chk("rst_dec_count", 32'(dec_count),     32'd0);
    chk("rst_sels",      {30'b0, dst_sel, const_sel}, 32'd0);
    chk("rst_consts",    const_ar | const_t, 32'd0);
    chk("rst_fields",    {16'b0, rd_ar, rd_t, rs1, rs2}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // first AR accept
    step(1'b1, 32'h1234_5ABC, 1'b1, 1'b0);
    chk("ar_rd_ar",    {28'b0, rd_ar}, 32'd3);
    chk("ar_rs1",      {28'b0, rs1},   32'd4);
    chk("ar_rs2",      {28'b0, rs2},   32'd5);
    chk("ar_const_ar", const_ar,       32'h0000_0ABC);
    chk("ar_sels",     {30'b0, dst_sel, const_sel}, 32'd0);
    chk("ar_count",    32'(dec_count), 32'd1);

    // T words, negative and positive immediates
    step(1'b1, 32'h5A00_8001, 1'b1, 1'b0);
    chk("t_sels",    {30'b0, dst_sel, const_sel}, 32'd3);
    chk("t_rd_t",    {28'b0, rd_t}, 32'hA);
    chk("t_const_n", const_t, 32'hFFFF_8001);
    step(1'b1, 32'h5A00_7FFF, 1'b1, 1'b0);
    chk("t_const_p", const_t, 32'h0000_7FFF);

    // back-pressure then full-throughput drain
    repeat (3) step(1'b1, 32'h0123_4567, 1'b0, 1'b0);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    step(1'b1, 32'h8765_4321, 1'b1, 1'b0);
    chk("br_is_branch", {31'b0, is_branch}, 32'd1);
    step(1'b1, 32'h0F0F_F0F0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // flush drops a coincident accept, next word decodes normally
    step(1'b1, 32'h4B00_1234, 1'b1, 1'b1);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_count", 32'(dec_count),     32'd5);
    step(1'b1, 32'h0300_0FFF, 1'b1, 1'b0);
    chk("post_flush_const_ar", const_ar, 32'h0000_0FFF);

    // counter wrap (CNT_W=4)
    for (int i = 0; i < 9; i++) begin
      step(1'b1, {2'($urandom_range(0, 2)), 30'($urandom)}, 1'b1, 1'b0);
    end
    chk("count_max", 32'(dec_count), 32'd15);
    step(1'b1, 32'h1000_0000, 1'b1, 1'b0);
    chk("count_wrap", 32'(dec_count), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // HALT word: one transfer, then input ignored
    step(1'b1, 32'hC000_0000, 1'b0, 1'b0);
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_valid",  {31'b0, out_valid}, 32'd1);
    chk("halt_sels",   {29'b0, dst_sel, const_sel, is_branch}, 32'd0);
    step(1'b1, 32'h0000_0001, 1'b1, 1'b0);
    repeat (3) step(1'b1, 32'h5000_0002, 1'b1, 1'b0);
    chk("halt_in_ready", {31'b0, in_ready}, 32'd0);
    chk("halt_count",    32'(dec_count),    32'd1);

    // asynchronous reset pulse away from the clock edge
    #2;
    reset = 1'b1;
    #1;
    chk("areset_halted", {31'b0, halted},   32'd0);
    chk("areset_count",  32'(dec_count),    32'd0);
    chk("areset_ready",  {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 32'h5A00_8001, 1'b1, 1'b0);
    chk("resume_const_t", const_t, 32'hFFFF_8001);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // flush while the HALT word is held keeps halted
    step(1'b1, 32'hC000_0000, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("halt_flush_valid",  {31'b0, out_valid}, 32'd0);
    chk("halt_flush_halted", {31'b0, halted},    32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ir_decode_stage.md
Name: ir_decode_stage

Overview:
- Pipeline register between instruction fetch and the register-bank (RB) write path.
- Captures one 32-bit instruction per handshake and classifies it as AR type (arithmetic register) or T type (transfer/immediate).
- Presents both candidate destination fields and both candidate 32-bit constants to the RB input muxes, with the select lines that choose between them.
- Also owns the HALT state and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of the decoded-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_instr  input  32  instruction word from fetch.
- in_valid  input  1  in_instr is valid.
- in_ready  output  1  stage can accept this cycle.
- flush  input  1  discard the held instruction (branch redirect).
- out_ready  input  1  RB stage consumes the held instruction.
- out_valid  output  1  held instruction is valid.
- rd_ar  output  4  AR-type destination field, instr[23:20].
- rd_t  output  4  T-type destination field, instr[27:24].
- const_ar  output  32  AR constant: zero-extended instr[11:0].
- const_t  output  32  T constant: sign-extended instr[15:0].
- dst_sel  output  1  0 selects rd_ar, 1 selects rd_t.
- const_sel  output  1  0 selects const_ar, 1 selects const_t.
- rs1  output  4  instr[19:16].
- rs2  output  4  instr[15:12].
- is_branch  output  1  class field 2'b10.
- halted  output  1  stage is in the HALT state.
- dec_count  output  CNT_W  number of instructions accepted.

Behaviour:
- Class field is instr[31:30]:
  - 00 = AR.
  - 01 = T.
  - 10 = branch (treated like AR for field selection).
  - 11 = HALT.
- Reset (async, active-high): all outputs 0, including out_valid, dst_sel, const_sel, halted and dec_count. FSM goes to RUN. Reset mid-transfer drops the held instruction.
- FSM has two states, RUN and HALT.
  - RUN -> HALT when a class-11 word is accepted.
  - HALT -> RUN only on reset.
- Handshake, in RUN:
  - in_ready = !out_valid | out_ready.
  - Accept when in_valid & in_ready.
  - Latency: exactly 1 cycle. Decoded fields appear on the cycle after acceptance, together with out_valid=1.
  - All decoded outputs are registered. No combinational path from in_instr to any output.
- Held data:
  - When out_valid=1 and out_ready=0, all outputs hold stable.
  - out_valid clears on out_ready with no new accept.
  - Back-to-back accept and consume in the same cycle gives full throughput: out_valid stays 1 and the fields update.
- Select rules: dst_sel = const_sel = 1 only for class 01. Both are 0 for classes 00, 10 and 11.
- HALT word:
  - Is accepted.
  - Produces out_valid=1 for one transfer, with selects 0 and is_branch 0.
  - Sets halted=1 in the same cycle out_valid rises.
  - From then on in_ready=0; once the HALT word is consumed, out_valid stays 0.
- flush (synchronous):
  - Clears out_valid next cycle.
  - Overrides a simultaneous accept: the word is dropped, but in_ready is still reported.
  - Does not change halted. A flush while the HALT word is held still leaves halted=1.
  - dec_count does not increment for a flushed accept.
- dec_count:
  - Increments by 1 on each non-flushed accept, HALT word included.
  - Wraps modulo 2^CNT_W (0xFFFF -> 0x0000).
- Arithmetic:
  - const_t = {{16{instr[15]}}, instr[15:0]}.
  - const_ar = {20'b0, instr[11:0]}.
  - Field outputs are valid for every class. For branch and HALT they are don't-care to the consumer, but must still equal the bit slices.

Test Plan:
- Reset with clk running and in_valid=1 -> all outputs 0 and in_ready=1. First accept of 0x1234_5ABC after deassert (class 00) -> next cycle out_valid=1, rd_ar=3, rs1=4, rs2=5, const_ar=0x0000_0ABC, dst_sel=0, const_sel=0, dec_count=1.
- T word 0x5A00_8001 (class 01, rd_t=0xA) -> dst_sel=1, const_sel=1, rd_t=0xA, const_t=0xFFFF_8001. With 0x5A00_7FFF -> const_t=0x0000_7FFF.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. Raise out_ready -> one word consumed per cycle with no bubble; dec_count matches accepts.
- flush asserted in the same cycle as an accept of a T word -> next cycle out_valid=0 and dec_count unchanged. The following word decodes normally.
- Accept 0xC000_0000 (HALT) -> halted=1, out_valid=1 for one transfer, then in_ready=0 forever and later in_valid is ignored. Async reset pulse mid-cycle -> halted=0 immediately and RUN resumes.
- Force dec_count to 0xFFFF via 65535 accepts (or CNT_W=4 build: 15) -> next accept wraps dec_count to 0.
